// File: rtl/csr_pkg.sv
// csr_pkg: shared op codes, CSR addresses, mstatus fields and FSM states
package csr_pkg;
    typedef enum logic [2:0] {
        OP_CSRRW  = 3'd0,
        OP_CSRRS  = 3'd1,
        OP_CSRRC  = 3'd2,
        OP_ECALL  = 3'd3,
        OP_EBREAK = 3'd4,
        OP_MRET   = 3'd5
    } op_e;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam int CAUSE_ECALL_M    = 11;
    localparam int CAUSE_BREAKPOINT = 3;
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR_OP,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STATUS,
        S_T_VEC,
        S_M_STATUS,
        S_M_EPC
    } state_e;
    function automatic logic is_csr_op(input logic [2:0] op);
        return op inside {OP_CSRRW, OP_CSRRS, OP_CSRRC};
    endfunction
endpackage

// File: rtl/csr_wdata_gen.sv
// csr_wdata_gen: CSR write data for Zicsr ops, trap entry and MRET per FSM phase
module csr_wdata_gen
    import csr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  state_e             phase_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   rdata_i,
    input  logic [WIDTH-1:0]   src_i,
    input  logic [WIDTH-1:0]   pc_i,
    output logic [WIDTH-1:0]   wdata_o
);
    logic [WIDTH-1:0] trap_st;
    logic [WIDTH-1:0] mret_st;
    always_comb begin
        trap_st = rdata_i;
        trap_st[MSTATUS_MPIE] = rdata_i[MSTATUS_MIE];
        trap_st[MSTATUS_MIE] = 1'b0;
        trap_st[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        mret_st = rdata_i;
        mret_st[MSTATUS_MIE] = rdata_i[MSTATUS_MPIE];
        mret_st[MSTATUS_MPIE] = 1'b1;
        mret_st[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        wdata_o = '0;
        case (phase_i)
            S_CSR_OP:   wdata_o = op_i == OP_CSRRS ? (rdata_i | src_i) :
                                  op_i == OP_CSRRC ? (rdata_i & ~src_i) : src_i;
            S_T_EPC:    wdata_o = pc_i;
            S_T_CAUSE:  wdata_o = WIDTH'(op_i == OP_EBREAK ? CAUSE_BREAKPOINT : CAUSE_ECALL_M);
            S_T_STATUS: wdata_o = trap_st;
            S_M_STATUS: wdata_o = mret_st;
            default:    wdata_o = '0;
        endcase
    end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences Zicsr RMW, trap entry and MRET over a single CSR port
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [11:0]        req_csr_addr,
    input  logic [WIDTH-1:0]   req_src,
    input  logic               req_src_zero,
    input  logic [WIDTH-1:0]   req_pc,
    output logic [11:0]        csr_addr,
    output logic               csr_wen,
    output logic [WIDTH-1:0]   csr_wdata,
    input  logic [WIDTH-1:0]   csr_rdata,
    output logic               resp_valid,
    output logic [WIDTH-1:0]   resp_rd_data,
    output logic               redirect_valid,
    output logic [WIDTH-1:0]   redirect_pc
);
    state_e           state_q;
    logic [2:0]       op_q;
    logic [11:0]      addr_q;
    logic [WIDTH-1:0] src_q;
    logic [WIDTH-1:0] pc_q;
    logic             src_zero_q;
    logic             accept;
    logic             legal;
    assign req_ready = state_q == S_IDLE;
    assign accept    = req_valid && req_ready;
    assign legal     = is_csr_op(op_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q       <= req_op;
                    addr_q     <= req_csr_addr;
                    src_q      <= req_src;
                    src_zero_q <= req_src_zero;
                    pc_q       <= req_pc;
                    // illegal op codes take the CSR_OP slot but never touch the port
                    state_q    <= (req_op == OP_ECALL || req_op == OP_EBREAK) ? S_T_EPC :
                                  req_op == OP_MRET ? S_M_STATUS : S_CSR_OP;
                end
                S_T_EPC:    state_q <= S_T_CAUSE;
                S_T_CAUSE:  state_q <= S_T_STATUS;
                S_T_STATUS: state_q <= S_T_VEC;
                S_M_STATUS: state_q <= S_M_EPC;
                default:    state_q <= S_IDLE;
            endcase
        end
    end
    always_comb begin
        csr_addr       = '0;
        csr_wen        = 1'b0;
        resp_valid     = 1'b0;
        resp_rd_data   = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            S_CSR_OP: begin
                csr_addr     = legal ? addr_q : '0;
                csr_wen      = legal && (op_q == OP_CSRRW || !src_zero_q);
                resp_valid   = 1'b1;
                resp_rd_data = legal ? csr_rdata : '0;
            end
            S_T_EPC: begin
                csr_addr = CSR_MEPC;
                csr_wen  = 1'b1;
            end
            S_T_CAUSE: begin
                csr_addr = CSR_MCAUSE;
                csr_wen  = 1'b1;
            end
            S_T_STATUS, S_M_STATUS: begin
                csr_addr = CSR_MSTATUS;
                csr_wen  = 1'b1;
            end
            S_T_VEC, S_M_EPC: begin
                csr_addr       = state_q == S_T_VEC ? CSR_MTVEC : CSR_MEPC;
                resp_valid     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_rdata[WIDTH-1:2], 2'b00};
            end
            default: ;
        endcase
    end
    csr_wdata_gen #(.WIDTH(WIDTH)) u_wdata (
        .phase_i (state_q),
        .op_i    (op_q),
        .rdata_i (csr_rdata),
        .src_i   (src_q),
        .pc_i    (pc_q),
        .wdata_o (csr_wdata)
    );
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: scoreboard bench with a CSR file model and a high-level trap/Zicsr reference
module tb_csr_trap_ctrl;
    localparam int RW = 0, RS = 1, RC = 2, ECALL = 3, EBREAK = 4, MRET = 5;
    logic        clk, rst;
    logic        req_valid, req_ready, req_src_zero;
    logic [2:0]  req_op;
    logic [11:0] req_csr_addr, csr_addr;
    logic [31:0] req_src, req_pc, csr_wdata, csr_rdata, resp_rd_data, redirect_pc;
    logic        csr_wen, resp_valid, redirect_valid;

    csr_trap_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_addr(req_csr_addr), .req_src(req_src), .req_src_zero(req_src_zero), .req_pc(req_pc),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .resp_valid(resp_valid), .resp_rd_data(resp_rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // environment CSR file: combinational read, write on clock edge
    logic [31:0] mem [8];
    logic        mem_clr;
    function automatic int cidx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            12'h340: return 4;
            12'h304: return 5;
            default: return 6;
        endcase
    endfunction
    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 8; i++) mem[i] <= 0;
        else if (csr_wen) mem[cidx(csr_addr)] <= csr_wdata;
    end
    assign csr_rdata = mem[cidx(csr_addr)];

    typedef struct { int due; logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int due; logic [31:0] rd; logic rv; logic [31:0] pc; } rs_t;
    wr_t wq[$];
    rs_t rq[$];
    wr_t we;
    rs_t re;
    int checks = 0, errors = 0, busy_until = -1;
    logic [31:0] m [int];
    logic [31:0] snap [int];
    logic [11:0] alist [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'h304};

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] rd_m(input int a);
        return m.exists(a) ? m[a] : 32'h0;
    endfunction

    // reference: architectural effect of each request, scheduled from its accept cycle
    task automatic model_issue(input int op, input int a, input logic [31:0] src, input logic sz,
                               input logic [31:0] pc, input int acc);
        logic [31:0] old, nw, st;
        int lat;
        if (op <= RC) begin
            old = rd_m(a);
            nw = op == RW ? src : op == RS ? (old | src) : (old & ~src);
            if (op == RW || !sz) begin
                wq.push_back('{acc, a[11:0], nw});
                m[a] = nw;
            end
            rq.push_back('{acc, old, 1'b0, 32'h0});
            lat = 1;
        end else if (op == ECALL || op == EBREAK) begin
            st = rd_m('h300);
            nw = (st & ~32'h1888) | 32'h1800 | (((st >> 3) & 1) << 7);
            wq.push_back('{acc, 12'h341, pc});
            wq.push_back('{acc + 1, 12'h342, op == ECALL ? 32'd11 : 32'd3});
            wq.push_back('{acc + 2, 12'h300, nw});
            m['h341] = pc;
            m['h342] = op == ECALL ? 32'd11 : 32'd3;
            m['h300] = nw;
            rq.push_back('{acc + 3, 32'h0, 1'b1, rd_m('h305) & ~32'h3});
            lat = 4;
        end else if (op == MRET) begin
            st = rd_m('h300);
            nw = (st & ~32'h1888) | 32'h1880 | (((st >> 7) & 1) << 3);
            wq.push_back('{acc, 12'h300, nw});
            m['h300] = nw;
            rq.push_back('{acc + 1, 32'h0, 1'b1, rd_m('h341) & ~32'h3});
            lat = 2;
        end else begin
            rq.push_back('{acc, 32'h0, 1'b0, 32'h0});
            lat = 1;
        end
        busy_until = acc + lat - 1;
    endtask

    task automatic finish_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic send(input int op, input int a, input logic [31:0] src, input logic sz,
                        input logic [31:0] pc);
        int w = 0;
        req_valid = 1;
        req_op = op[2:0];
        req_csr_addr = a[11:0];
        req_src = src;
        req_src_zero = sz;
        req_pc = pc;
        do begin
            @(negedge clk);
            w++;
        end while (!req_ready && w < 30);
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 30 cycles");
            finish_up();
        end
        @(posedge clk);
        #1;
        model_issue(op, a, src, sz, pc, cyc);
        req_valid = 0;
        req_op = 3'($urandom);
        req_csr_addr = 12'($urandom);
        req_src = $urandom;
        req_src_zero = 1'($urandom);
        req_pc = $urandom;
    endtask

    always @(negedge clk) begin
        chk("req_ready", {31'h0, req_ready}, {31'h0, cyc > busy_until});
        while (wq.size() > 0 && wq[0].due < cyc) begin
            we = wq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_write: got none expected [%h]<=%h", we.addr, we.data);
        end
        while (rq.size() > 0 && rq[0].due < cyc) begin
            re = rq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_resp: got none expected rd=%h redir=%h", re.rd, re.pc);
        end
        if (csr_wen) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got [%h]<=%h expected no write", csr_addr, csr_wdata);
            end else begin
                we = wq.pop_front();
                chk("wr_cycle", cyc, we.due);
                chk("wr_addr", {20'h0, csr_addr}, {20'h0, we.addr});
                chk("wr_data", csr_wdata, we.data);
            end
        end
        if (resp_valid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got rd=%h expected no response", resp_rd_data);
            end else begin
                re = rq.pop_front();
                chk("resp_cycle", cyc, re.due);
                chk("resp_rd_data", resp_rd_data, re.rd);
                chk("redirect_valid", {31'h0, redirect_valid}, {31'h0, re.rv});
                chk("redirect_pc", redirect_pc, re.pc);
            end
        end else begin
            chk("quiet_rd_data", resp_rd_data, 32'h0);
            chk("quiet_redirect", {redirect_valid, redirect_pc[30:0]}, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int r, op, a;
        logic [31:0] src;
        logic sz;
        rst = 1;
        mem_clr = 1;
        req_valid = 0;
        req_op = 0;
        req_csr_addr = 0;
        req_src = 0;
        req_src_zero = 0;
        req_pc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wen", {31'h0, csr_wen}, 32'h0);
        chk("reset_addr", {20'h0, csr_addr}, 32'h0);
        rst = 0;
        mem_clr = 0;
        send(RW, 'h305, 32'h80000104, 0, 32'h0);
        send(RW, 'h300, 32'h1888, 0, 32'h0);
        send(RS, 'h300, 32'h0, 1, 32'h0);
        send(RC, 'h300, 32'h8, 0, 32'h0);
        send(RW, 'h300, 32'h8, 0, 32'h0);
        send(ECALL, 0, 32'h0, 0, 32'h80000010);
        send(MRET, 0, 32'h0, 0, 32'h0);
        // abandon an ECALL while mcause is being written
        send(RW, 'h300, 32'h8, 0, 32'h0);
        snap = m;
        send(ECALL, 0, 32'h0, 0, 32'h80000020);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrst_wen", {31'h0, csr_wen}, 32'h0);
        chk("midrst_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_resp", {31'h0, resp_valid}, 32'h0);
        m = snap;
        m['h341] = 32'h80000020;
        wq.delete();
        rq.delete();
        busy_until = cyc - 1;
        @(posedge clk);
        #1;
        rst = 0;
        send(RW, 'h300, 32'h0, 0, 32'h0);
        send(RW, 'h300, 32'h88, 0, 32'h0);
        send(EBREAK, 0, 32'h0, 0, 32'h80000040);
        send(RW, 'h340, 32'h12345678, 0, 32'h0);
        send(6, 'h300, 32'hffffffff, 0, 32'h0);
        send(7, 'h305, 32'hffffffff, 0, 32'h0);
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 19);
            op = r < 5 ? RW : r < 9 ? RS : r < 13 ? RC : r < 15 ? ECALL : r < 16 ? EBREAK :
                 r < 18 ? MRET : r - 12;
            a = int'(alist[$urandom_range(0, 5)]);
            sz = $urandom_range(0, 3) == 0;
            src = sz ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(op, a, src, sz, $urandom);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("drain", wq.size() + rq.size(), 32'h0);
        finish_up();
    end
endmodule
